// File: rtl/branch_target_predictor.sv
// Branch/jump target resolve unit with a direct-mapped BTB; BTB_2BIT_COUNTER_EN adds 2-bit taken counters.
// Latency: lookup is combinational, resolve result registered one cycle after ex_valid.
// Backpressure: none; every valid resolve is accepted and trains the BTB in the same edge.
module branch_target_predictor #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_addr,
  input  logic            ex_valid,
  input  logic [1:0]      ex_type,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_imm_b,
  input  logic [XLEN-1:0] ex_imm_j,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic            ex_taken,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_addr,
  output logic            res_valid,
  output logic [XLEN-1:0] res_target,
  output logic            res_mispredict
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_BR   = 2'b01;
  localparam logic [1:0] TYPE_JAL  = 2'b10;
  localparam logic [1:0] TYPE_JALR = 2'b11;

  logic [BTB_ENTRIES-1:0] btb_vld;
  logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_tgt [BTB_ENTRIES];
`ifdef BTB_2BIT_COUNTER_EN
  logic [1:0]             btb_ctr [BTB_ENTRIES];
`endif

  // Fetch-side lookup
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic             if_dec;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[XLEN-1:IDX_W+2];
  assign if_hit = btb_vld[if_idx] && (btb_tag[if_idx] == if_tag);
`ifdef BTB_2BIT_COUNTER_EN
  assign if_dec = btb_ctr[if_idx][1];
`else
  assign if_dec = 1'b1;
`endif
  assign if_pred_taken = if_hit & if_dec;
  assign if_pred_addr  = if_pred_taken ? btb_tgt[if_idx] : if_pc + XLEN'(4);

  // Execute-side resolve
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic [XLEN-1:0]  ex_target;
  logic             ex_act_taken;
  logic [XLEN-1:0]  ex_next;
  logic             ex_misp;
  logic             ex_upd;

  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX_W+2];
  assign ex_hit = btb_vld[ex_idx] && (btb_tag[ex_idx] == ex_tag);

  always_comb begin
    ex_target    = ex_pc + ex_imm_b;
    ex_act_taken = 1'b1;
    case (ex_type)
      TYPE_BR: begin
        ex_target    = ex_pc + ex_imm_b;
        ex_act_taken = ex_taken;
      end
      TYPE_JAL:  ex_target = ex_pc + ex_imm_j;
      TYPE_JALR: ex_target = (ex_rs1 + ex_imm_i) & ~XLEN'(1);
      default:   ex_target = ex_pc + ex_imm_b;
    endcase
    ex_next = ex_act_taken ? ex_target : ex_pc + XLEN'(4);
    ex_misp = (ex_act_taken != ex_pred_taken) |
              (ex_act_taken & (ex_target != ex_pred_addr));
    ex_upd  = ex_valid & (ex_type != TYPE_NONE) & ~flush;
  end

`ifdef BTB_2BIT_COUNTER_EN
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      res_valid      <= 1'b0;
      res_target     <= '0;
      res_mispredict <= 1'b0;
      btb_vld        <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_tag[i] <= '0;
        btb_tgt[i] <= '0;
`ifdef BTB_2BIT_COUNTER_EN
        btb_ctr[i] <= 2'b01;
`endif
      end
    end else begin
      res_valid <= ex_upd;
      if (ex_upd) begin
        res_target     <= ex_next;
        res_mispredict <= ex_misp;
      end
      // Flush wins over any concurrent training write
      if (flush) begin
        btb_vld <= '0;
      end else if (ex_upd) begin
        if (ex_act_taken) begin
          btb_vld[ex_idx] <= 1'b1;
          btb_tag[ex_idx] <= ex_tag;
          btb_tgt[ex_idx] <= ex_target;
`ifdef BTB_2BIT_COUNTER_EN
          btb_ctr[ex_idx] <= ex_hit ? sat_inc(btb_ctr[ex_idx]) : 2'b10;
`endif
        end else if (ex_hit) begin
`ifdef BTB_2BIT_COUNTER_EN
          btb_ctr[ex_idx] <= sat_dec(btb_ctr[ex_idx]);
`else
          btb_vld[ex_idx] <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: resolve targets, mispredicts, BTB training,
// aliasing, address wrap, async reset and flush; follows BTB_2BIT_COUNTER_EN when defined.
module tb_branch_target_predictor;

  localparam int XLEN = 32;
  localparam logic [1:0] T_BR   = 2'b01;
  localparam logic [1:0] T_JAL  = 2'b10;
  localparam logic [1:0] T_JALR = 2'b11;

  logic            CLK;
  logic            RST;
  logic            flush;
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic [XLEN-1:0] if_pred_addr;
  logic            ex_valid;
  logic [1:0]      ex_type;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_imm_b;
  logic [XLEN-1:0] ex_imm_j;
  logic [XLEN-1:0] ex_imm_i;
  logic            ex_taken;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_addr;
  logic            res_valid;
  logic [XLEN-1:0] res_target;
  logic            res_mispredict;

  int checks = 0;
  int errors = 0;

  branch_target_predictor #(.XLEN(XLEN), .BTB_ENTRIES(16)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_addr(if_pred_addr),
    .ex_valid(ex_valid), .ex_type(ex_type), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
    .ex_imm_b(ex_imm_b), .ex_imm_j(ex_imm_j), .ex_imm_i(ex_imm_i),
    .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken), .ex_pred_addr(ex_pred_addr),
    .res_valid(res_valid), .res_target(res_target), .res_mispredict(res_mispredict)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [XLEN-1:0] pc,
                        input logic exp_taken, input logic [XLEN-1:0] exp_addr);
    if_pc = pc;
    #1;
    check({tag, "_taken"}, {31'd0, if_pred_taken}, {31'd0, exp_taken});
    check({tag, "_addr"}, if_pred_addr, exp_addr);
  endtask

  task automatic drive(input logic [1:0] typ, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                       input logic tk, input logic ptk, input logic [XLEN-1:0] paddr);
    ex_valid      = 1'b1;
    ex_type       = typ;
    ex_pc         = pc;
    ex_imm_b      = imm;
    ex_imm_j      = imm;
    ex_imm_i      = imm;
    ex_taken      = tk;
    ex_pred_taken = ptk;
    ex_pred_addr  = paddr;
  endtask

  task automatic resolve(input string tag, input logic [XLEN-1:0] exp_tgt, input logic exp_misp);
    step();
    ex_valid = 1'b0;
    check({tag, "_vld"}, {31'd0, res_valid}, 32'd1);
    check({tag, "_tgt"}, res_target, exp_tgt);
    check({tag, "_misp"}, {31'd0, res_mispredict}, {31'd0, exp_misp});
  endtask

  initial begin
    RST = 1'b0; flush = 1'b0; if_pc = 32'h100;
    ex_valid = 1'b0; ex_type = 2'b00; ex_pc = '0; ex_rs1 = '0;
    ex_imm_b = '0; ex_imm_j = '0; ex_imm_i = '0;
    ex_taken = 1'b0; ex_pred_taken = 1'b0; ex_pred_addr = '0;
    #1 RST = 1'b1;
    #2;
    check("rst_res_vld", {31'd0, res_valid}, 32'd0);
    check("rst_res_tgt", res_target, 32'd0);
    check("rst_res_misp", {31'd0, res_mispredict}, 32'd0);
    lookup("rst_lk", 32'h100, 1'b0, 32'h104);
    @(negedge CLK);
    RST = 1'b0;

    // JAL trains BTB; mispredicted because fetch predicted not-taken
    drive(T_JAL, 32'h100, 32'h40, 1'b0, 1'b0, 32'h0);
    resolve("jal", 32'h140, 1'b1);
    lookup("jal_lk", 32'h100, 1'b1, 32'h140);
    step();
    check("hold_vld", {31'd0, res_valid}, 32'd0);
    check("hold_tgt", res_target, 32'h140);
    check("hold_misp", {31'd0, res_mispredict}, 32'd1);

    // JALR clears bit 0 of the sum; prediction matches
    drive(T_JALR, 32'h104, 32'h10, 1'b0, 1'b1, 32'h2010);
    ex_rs1 = 32'h2001;
    resolve("jalr", 32'h2010, 1'b0);
    lookup("jalr_lk", 32'h104, 1'b1, 32'h2010);

    // Branch taken, then not-taken twice, then taken again
    drive(T_BR, 32'h200, 32'h20, 1'b1, 1'b0, 32'h0);
    resolve("br1", 32'h220, 1'b1);
    lookup("br1_lk", 32'h200, 1'b1, 32'h220);
    drive(T_BR, 32'h200, 32'h20, 1'b0, 1'b1, 32'h220);
    resolve("br2", 32'h204, 1'b1);
    lookup("br2_lk", 32'h200, 1'b0, 32'h204);
    drive(T_BR, 32'h200, 32'h20, 1'b0, 1'b0, 32'h204);
    resolve("br3", 32'h204, 1'b0);
    lookup("br3_lk", 32'h200, 1'b0, 32'h204);
    drive(T_BR, 32'h200, 32'h20, 1'b1, 1'b0, 32'h204);
    resolve("br4", 32'h220, 1'b1);
`ifdef BTB_2BIT_COUNTER_EN
    // counter floored at 00, one increment leaves it weakly not-taken
    lookup("br4_lk", 32'h200, 1'b0, 32'h204);
`else
    lookup("br4_lk", 32'h200, 1'b1, 32'h220);
`endif

    // Aliasing: 0x100 and 0x140 share index 0 with different tags
    drive(T_JAL, 32'h100, 32'h40, 1'b0, 1'b1, 32'h140);
    resolve("al1", 32'h140, 1'b0);
    lookup("al1_lk", 32'h140, 1'b0, 32'h144);
    drive(T_JAL, 32'h140, 32'h40, 1'b0, 1'b0, 32'h0);
    resolve("al2", 32'h180, 1'b1);
    lookup("al2_lk_old", 32'h100, 1'b0, 32'h104);
    lookup("al2_lk_new", 32'h140, 1'b1, 32'h180);

    // Address wrap, then async reset while res_valid is high
    drive(T_BR, 32'hFFFF_FFFC, 32'h8, 1'b1, 1'b0, 32'h0);
    resolve("wrap", 32'h0000_0004, 1'b1);
    lookup("wrap_lk", 32'hFFFF_FFFC, 1'b1, 32'h0000_0004);
    drive(T_JAL, 32'h104, 32'h80, 1'b0, 1'b0, 32'h0);
    step();
    check("pre_rst_vld", {31'd0, res_valid}, 32'd1);
    RST = 1'b1;
    #1;
    check("mid_rst_vld", {31'd0, res_valid}, 32'd0);
    check("mid_rst_tgt", res_target, 32'd0);
    lookup("mid_rst_lk", 32'hFFFF_FFFC, 1'b0, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    ex_valid = 1'b0;
    step();
    lookup("post_rst_lk", 32'h104, 1'b0, 32'h108);

    // Flush with a concurrent update: both the old entry and the new write are gone
    drive(T_JAL, 32'h100, 32'h40, 1'b0, 1'b0, 32'h0);
    resolve("pre_fl", 32'h140, 1'b1);
    lookup("pre_fl_lk", 32'h100, 1'b1, 32'h140);
    drive(T_JAL, 32'h104, 32'h40, 1'b0, 1'b0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    ex_valid = 1'b0;
    check("fl_vld", {31'd0, res_valid}, 32'd0);
    check("fl_tgt_hold", res_target, 32'h140);
    lookup("fl_lk_old", 32'h100, 1'b0, 32'h104);
    lookup("fl_lk_new", 32'h104, 1'b0, 32'h108);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
